// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port MIPS32 register file:
// clear/run FSM states, register-name constants and the depth helper.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: selects a storage word and applies the
// $zero hardwiring and same-cycle write bypass on top of it.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              ready,
  input  logic [DATA_W-1:0] mem [rf_depth(ADDR_W)],
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata
);

  // The write enables arriving here are already qualified, so a bypass
  // only ever forwards data that will really be committed at the edge.
  always_comb begin
    rdata = '0;
    if (ready && !(ZERO_REG != 0 && raddr == ADDR_W'(REG_ZERO))) begin
      rdata = mem[raddr];
      if (BYPASS != 0) begin
        if (we1 && waddr1 == raddr) begin
          rdata = wdata1;
        end else if (we0 && waddr0 == raddr) begin
          rdata = wdata0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file: NUM_RD read ports, two write
// ports (port 1 wins on collision) and a sequenced clear after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     wr_conflict
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  rf_state_t         state;
  rf_state_t         state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic              wr0_en;
  logic              wr1_en;
  logic              conflict_next;

  // Writes to $zero are dropped before arbitration, so two writes that both
  // target register 0 never raise a conflict.
  assign wr0_en = ready && !reset && we0 &&
                  !(ZERO_REG != 0 && waddr0 == ADDR_W'(REG_ZERO));
  assign wr1_en = ready && !reset && we1 &&
                  !(ZERO_REG != 0 && waddr1 == ADDR_W'(REG_ZERO));
  assign conflict_next = wr0_en && wr1_en && (waddr0 == waddr1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RF_CLEAR;
      clr_ptr     <= '0;
      ready       <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      state       <= state_next;
      ready       <= (state_next == RF_RUN);
      wr_conflict <= conflict_next;
      if (state == RF_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (state == RF_CLEAR && clr_ptr == ADDR_W'(DEPTH - 1)) begin
      state_next = RF_RUN;
    end
  end

  // Port 1 is assigned last so it overrides port 0 on an address collision.
  always_ff @(posedge clk) begin
    if (!reset && state == RF_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      if (wr0_en) begin
        mem[waddr0] <= wdata0;
      end
      if (wr1_en) begin
        mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .ready (ready),
      .mem   (mem),
      .raddr (raddr[k*ADDR_W +: ADDR_W]),
      .we0   (wr0_en),
      .waddr0(waddr0),
      .wdata0(wdata0),
      .we1   (wr1_en),
      .waddr1(waddr1),
      .wdata1(wdata1),
      .rdata (rdata[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing 4-read-port instance and a
// non-bypassing 2-read-port instance share stimulus and one reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b1;
  logic          reset;
  logic          we0, we1;
  logic [AW-1:0] waddr0, waddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [4*AW-1:0] raddr;
  logic [4*DW-1:0] rdata;
  logic [2*DW-1:0] rdata_nb;
  logic          ready, ready_nb, wr_conflict, conflict_nb;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .wr_conflict(wr_conflict)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ready(ready_nb),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr[2*AW-1:0]), .rdata(rdata_nb), .wr_conflict(conflict_nb)
  );

  typedef struct {
    bit            check;
    bit            rdy;
    bit            conf;
    logic [DW-1:0] rd [4];
    logic [DW-1:0] rdnb [2];
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_cnt   = 0;
  bit            ref_ready = 0;
  bit            ref_conf  = 0;
  int            checks    = 0;
  int            errors    = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Architectural view of a read: $zero is 0, bypass forwards same-cycle writes.
  function automatic logic [DW-1:0] refRead(input int a, input bit byp,
      input bit e0, input int a0, input logic [DW-1:0] d0,
      input bit e1, input int a1, input logic [DW-1:0] d1);
    if (!ref_ready || a == 0) return '0;
    if (byp && e1 && a1 == a) return d1;
    if (byp && e0 && a0 == a) return d0;
    return ref_mem[a];
  endfunction

  task automatic applyStimulus(input bit rst,
      input bit w0, input int a0, input logic [DW-1:0] d0,
      input bit w1, input int a1, input logic [DW-1:0] d1,
      input int r0, input int r1, input int r2, input int r3, input bit chk);
    exp_t e;
    bit   e0, e1;
    int   ra [4];
    ra = '{r0, r1, r2, r3};
    reset  = rst;
    we0    = w0;  waddr0 = a0[AW-1:0]; wdata0 = d0;
    we1    = w1;  waddr1 = a1[AW-1:0]; wdata1 = d1;
    raddr  = {r3[AW-1:0], r2[AW-1:0], r1[AW-1:0], r0[AW-1:0]};
    e0 = w0 && ref_ready && !rst && a0 != 0;
    e1 = w1 && ref_ready && !rst && a1 != 0;
    e.check = chk;
    e.rdy   = ref_ready;
    e.conf  = ref_conf;
    for (int k = 0; k < 4; k++) e.rd[k] = refRead(ra[k], 1, e0, a0, d0, e1, a1, d1);
    for (int k = 0; k < 2; k++) e.rdnb[k] = refRead(ra[k], 0, e0, a0, d0, e1, a1, d1);
    expq.push_back(e);
    @(posedge clk);
    if (rst) begin
      ref_cnt   = 0;
      ref_ready = 0;
      ref_conf  = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      ref_conf = e0 && e1 && a0 == a1;
      if (ref_ready) begin
        if (e0) ref_mem[a0] = d0;
        if (e1) ref_mem[a1] = d1;
      end else begin
        ref_cnt++;
        if (ref_cnt == DEPTH) ref_ready = 1;
      end
    end
    #1;
  endtask

  task automatic idleCycle(input bit rst, input int r0, input int r1, input int r2, input int r3);
    applyStimulus(rst, 0, 0, '0, 0, 0, '0, r0, r1, r2, r3, 1);
  endtask

  // Bias random addresses toward a small set so collisions and $zero hits occur.
  function automatic int pickAddr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 8) return 29;
    if (sel == 9) return 31;
    return sel;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      if (e.check) begin
        checkOutput("ready", DW'(ready), DW'(e.rdy));
        checkOutput("ready_nb", DW'(ready_nb), DW'(e.rdy));
        checkOutput("wr_conflict", DW'(wr_conflict), DW'(e.conf));
        checkOutput("wr_conflict_nb", DW'(conflict_nb), DW'(e.conf));
        for (int k = 0; k < 4; k++)
          checkOutput($sformatf("rdata[%0d]", k), rdata[k*DW +: DW], e.rd[k]);
        for (int k = 0; k < 2; k++)
          checkOutput($sformatf("rdata_nb[%0d]", k), rdata_nb[k*DW +: DW], e.rdnb[k]);
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0);

    // Clear sequence with random write attempts that must be ignored.
    for (int i = 0; i < 33; i++)
      applyStimulus(0, 1'($urandom), pickAddr(), $urandom, 1'($urandom), pickAddr(), $urandom,
                    pickAddr(), pickAddr(), pickAddr(), pickAddr(), 1);

    applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, '0, 5, 5, 5, 5, 1);
    idleCycle(0, 5, 5, 5, 5);

    applyStimulus(0, 1, 7, 32'h1, 1, 7, 32'h2, 7, 7, 5, 7, 1);
    idleCycle(0, 7, 7, 7, 7);
    idleCycle(0, 7, 7, 7, 7);

    applyStimulus(0, 0, 0, '0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    idleCycle(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h3, 1, 0, 32'h4, 0, 0, 0, 0, 1);
    idleCycle(0, 0, 0, 0, 0);

    applyStimulus(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 2, 3, 31, 1);
    applyStimulus(0, 1, 3, 32'h33, 1, 31, 32'hFF, 1, 2, 3, 31, 1);
    idleCycle(0, 1, 2, 3, 31);

    for (int i = 0; i < 400; i++)
      applyStimulus(0, 1'($urandom), pickAddr(), $urandom, 1'($urandom), pickAddr(), $urandom,
                    pickAddr(), pickAddr(), pickAddr(), pickAddr(), 1);

    // Reset re-asserted partway through a clear must restart the whole sequence.
    applyStimulus(0, 1, 31, 32'h55, 0, 0, '0, 31, 31, 31, 31, 1);
    idleCycle(0, 31, 31, 31, 31);
    idleCycle(1, 31, 31, 31, 31);
    for (int i = 0; i < 10; i++) idleCycle(0, 31, 31, 31, 31);
    idleCycle(1, 31, 31, 31, 31);
    for (int i = 0; i < 34; i++) idleCycle(0, 31, 30, 1, 31);

    repeat (2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
